// File: rtl/elevator_panel_pkg.sv
// Shared constants for the elevator operator-panel input block.
package elevator_panel_pkg;
  localparam int N_FLOORS            = 3;
  localparam int FLOOR1              = 0;
  localparam int FLOOR2              = 1;
  localparam int FLOOR3              = 2;
  localparam int DEF_MAX_PEOPLE      = 6;
  localparam int DEF_DEBOUNCE_CYCLES = 8;
  // Debounce channel map: buttons occupy 0..N_FLOORS-1, switches follow.
  localparam int CH_SOS              = 3;
  localparam int CH_WFLIP            = 4;
  localparam int CH_WRST             = 5;
  localparam int N_CH                = 6;
endpackage

// File: rtl/panel_debounce.sv
// One panel channel: 2-flop synchroniser, consecutive-sample debouncer and
// look-ahead edge flags that are true in the cycle before the stable value flips.
module panel_debounce #(
  parameter int   DEBOUNCE_CYCLES = 8,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_arm,
  output logic o_stable,
  output logic o_stable_nxt,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = r_sync[1] != r_stable;
  assign w_done = !i_arm && w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // While armed the stable value tracks the synchroniser silently.
  assign o_stable_nxt = (i_arm || w_done) ? r_sync[1] : r_stable;
  assign o_rise_nxt   = w_done &  r_sync[1];
  assign o_fall_nxt   = w_done & ~r_sync[1];
  assign o_stable     = r_stable;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= {2{RESET_LEVEL}};
      r_stable <= RESET_LEVEL;
      r_cnt    <= '0;
    end else begin
      r_sync   <= {r_sync[0], i_raw};
      r_stable <= o_stable_nxt;
      r_cnt    <= (i_arm || !w_diff || w_done) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/elevator_panel_input.sv
// Operator-panel front end: debounced call pulses/lamps, SOS level, occupancy.
// Optional stuck-button detection is enabled with PANEL_STUCK_BUTTON_EN.
module elevator_panel_input
  import elevator_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MAX_PEOPLE      = DEF_MAX_PEOPLE,
  parameter int CNT_W           = 4,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic             clk_50,
  input  logic             button_reset_pushed,
  input  logic             button1_pushed,
  input  logic             button2_pushed,
  input  logic             button3_pushed,
  input  logic             sos_flip,
  input  logic             weight_flip,
  input  logic             weight_flip_reset,
  input  logic [2:0]       arrived_floor,
  output logic [2:0]       call_pulse,
  output logic [2:0]       call_pending,
  output logic             sos_mode,
  output logic [CNT_W-1:0] people_count,
  output logic             weight_limit_exceeded,
  output logic [2:0]       button_stuck
);
  localparam int ARM = DEBOUNCE_CYCLES + 2;
  localparam int AW  = $clog2(ARM + 1);

  logic [N_CH-1:0]     w_raw, w_stable, w_stable_nxt, w_rise_nxt, w_fall_nxt;
  logic [AW-1:0]       r_arm_cnt;
  logic                w_arm;
  logic                w_sos_nxt;
  logic [N_FLOORS-1:0] w_stuck_nxt, w_pulse_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_unused;

  assign w_raw = {weight_flip_reset, weight_flip, sos_flip,
                  button3_pushed, button2_pushed, button1_pushed};
  assign w_arm = r_arm_cnt != AW'(ARM);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (g < N_FLOORS)
    ) u_db (
      .i_clk       (clk_50),
      .i_rst_n     (button_reset_pushed),
      .i_raw       (w_raw[g]),
      .i_arm       ((g >= N_FLOORS) ? w_arm : 1'b0),
      .o_stable    (w_stable[g]),
      .o_stable_nxt(w_stable_nxt[g]),
      .o_rise_nxt  (w_rise_nxt[g]),
      .o_fall_nxt  (w_fall_nxt[g])
    );
  end

  assign w_unused = ^{w_rise_nxt[N_FLOORS-1:0], w_stable[N_CH-1:CH_WFLIP],
                      w_stable_nxt[N_CH-1:CH_WFLIP], w_stable_nxt[N_FLOORS-1:0],
                      w_fall_nxt[N_CH-1:CH_SOS], w_rise_nxt[CH_SOS]};

`ifdef PANEL_STUCK_BUTTON_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  logic [N_FLOORS-1:0][SW-1:0] r_hold;
  logic [N_FLOORS-1:0]         r_stuck;

  always_comb begin
    w_stuck_nxt = r_stuck;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (w_rise_nxt[i])
        w_stuck_nxt[i] = 1'b0;
      else if (!w_stable[i] && r_hold[i] == SW'(STUCK_CYCLES - 1))
        w_stuck_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge button_reset_pushed) begin
    if (!button_reset_pushed) begin
      r_hold  <= '0;
      r_stuck <= '0;
    end else begin
      for (int i = 0; i < N_FLOORS; i++) begin
        if (w_stable[i])
          r_hold[i] <= '0;
        else if (r_hold[i] != SW'(STUCK_CYCLES))
          r_hold[i] <= r_hold[i] + 1'b1;
      end
      r_stuck <= w_stuck_nxt;
    end
  end
  assign button_stuck = r_stuck;
`else
  assign w_stuck_nxt  = '0;
  assign button_stuck = '0;
`endif

  // Gate on the next SOS level so pending lamps are never lit while sos_mode is 1.
  assign w_sos_nxt   = w_stable_nxt[CH_SOS];
  assign w_pulse_nxt = w_fall_nxt[N_FLOORS-1:0] & ~w_stuck_nxt & {N_FLOORS{~w_sos_nxt}};
  assign sos_mode    = w_stable[CH_SOS];

  always_comb begin
    w_cnt_nxt = people_count;
    if (w_rise_nxt[CH_WRST])
      w_cnt_nxt = '0;
    else if (w_rise_nxt[CH_WFLIP] && people_count != {CNT_W{1'b1}})
      w_cnt_nxt = people_count + 1'b1;
  end

  always_ff @(posedge clk_50 or negedge button_reset_pushed) begin
    if (!button_reset_pushed) begin
      r_arm_cnt             <= '0;
      call_pulse            <= '0;
      call_pending          <= '0;
      people_count          <= '0;
      weight_limit_exceeded <= 1'b0;
    end else begin
      if (w_arm) r_arm_cnt <= r_arm_cnt + 1'b1;
      call_pulse            <= w_pulse_nxt;
      call_pending          <= w_sos_nxt ? '0
                             : (call_pending | w_pulse_nxt) & ~arrived_floor & ~w_stuck_nxt;
      people_count          <= w_cnt_nxt;
      weight_limit_exceeded <= int'(w_cnt_nxt) > MAX_PEOPLE;
    end
  end
endmodule

// File: doc/elevator_panel_input.md
Name: elevator_panel_input

Overview:
- Receives the raw operator-panel signals that drive the elevator TOP: three active-low floor call buttons, the SOS switch, the occupant-entry switch and the occupant-reset switch.
- Synchronises and debounces every input, then converts the clean levels and edges into controller-facing outputs:
  - one-cycle call pulses;
  - latched call-pending lamps;
  - the sos_mode level;
  - a saturating occupant count and the weight-limit flag.
- Sits between the panel pins and the floor/door controller state machine.

Parameters:
- DEBOUNCE_CYCLES, 8: consecutive cycles a synchronised input must differ from its stable value before the stable value updates.
- MAX_PEOPLE, 6: weight_limit_exceeded asserts when count > MAX_PEOPLE.
- CNT_W, 4: occupant counter width.
- STUCK_CYCLES, 1000: hold time for the stuck-button detector (optional feature only).

Ports:
- clk_50  in  1  system clock.
- button_reset_pushed  in  1  asynchronous active-low reset.
- button1_pushed, button2_pushed, button3_pushed  in  1 each  raw call buttons, active-low (idle 1).
- sos_flip  in  1  raw SOS switch level.
- weight_flip  in  1  raw switch; each debounced 0->1 transition adds one occupant.
- weight_flip_reset  in  1  raw switch; each debounced 0->1 transition clears the count.
- arrived_floor  in  3  one-hot from the controller, bit i = floor i+1 served.
- call_pulse  out  3  one-cycle debounced press event per floor.
- call_pending  out  3  latched requests; drive led1..led3.
- sos_mode  out  1  debounced SOS switch level.
- people_count  out  CNT_W  current occupants.
- weight_limit_exceeded  out  1  people_count > MAX_PEOPLE.
- button_stuck  out  3  stuck-button flags; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on button_reset_pushed.
  - While low, all outputs are 0 and all counters and debounce state are cleared.
  - Button stable values reset to 1; switch stable values reset to 0.
- Synchronisation and debounce, per channel:
  - Each input passes through a 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synchronised value differs from the stable value. It clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the stable value takes the synchronised value and the counter clears.
  - Latency from the first clock edge sampling a new raw level to the stable-value update is DEBOUNCE_CYCLES+2 edges (10 at default).
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Arming window:
  - For the first DEBOUNCE_CYCLES+2 cycles after reset release, the switch stable values load directly from the synchroniser with no events generated.
  - This stops a switch already at 1 from producing a spurious increment.
- Buttons:
  - A debounced 1->0 transition on channel i raises call_pulse[i] for exactly one cycle, registered.
  - The same edge sets call_pending[i].
  - A 0->1 release produces no event.
- Clearing call_pending[i]:
  - arrived_floor[i]=1 clears call_pending[i].
  - If a set and a clear land in the same cycle, the clear wins.
- SOS:
  - sos_mode equals the debounced sos_flip level.
  - While sos_mode=1, all call_pending bits are held at 0 and call_pulse is suppressed.
  - A press whose debounce completes during SOS is discarded, not deferred.
- Occupancy:
  - A debounced weight_flip 0->1 transition increments people_count, saturating at 2^CNT_W-1.
  - A debounced weight_flip_reset 0->1 transition sets people_count to 0.
  - If both occur in the same cycle, the reset wins and the result is 0.
- weight_limit_exceeded:
  - It is a registered compare on the next count value, so it updates on the same edge as people_count.
- Independence: all channels are independent, so simultaneous presses on several floors each pulse in the same cycle.

Optional Feature:
- Macro: PANEL_STUCK_BUTTON_EN.
- When defined:
  - A per-button hold counter runs while the debounced level is 0.
  - button_stuck[i] sets when the hold reaches STUCK_CYCLES.
  - While button_stuck[i] is set, channel i's call_pending and call_pulse are forced to 0.
  - button_stuck[i] clears on the debounced release.
- When undefined: button_stuck = 3'b000 and no hold counters are synthesised.

Decomposition:
- Package elevator_panel_pkg holds:
  - N_FLOORS=3;
  - floor-index constants FLOOR1..FLOOR3 = 0..2;
  - default MAX_PEOPLE;
  - default DEBOUNCE_CYCLES.
- Sub-module panel_debounce: a single-channel synchroniser, debouncer and rise/fall pulse generator.
  - Parameters: DEBOUNCE_CYCLES and RESET_LEVEL.
  - Instantiated six times.
- The top level holds the call latches, SOS gating, occupancy counter, arming counter and optional stuck logic.

Test Plan (all scenarios use default parameters):
- Reset mid-operation: reach people_count=5, sos_flip=1, call_pending=3'b100, then pull button_reset_pushed low between edges. All outputs must go to 0 immediately, with no spurious events during the arming window after release.
- Single press: drive button2_pushed low for 30 cycles. call_pulse must be 3'b010 for exactly one cycle, 10 edges after the press is sampled. call_pending[1] must stay 1 until arrived_floor=3'b010, then drop on the next edge.
- Bounce rejection: drive button1_pushed low for 5 cycles, high for 2, low for 5, then high. No call_pulse and call_pending stays 0.
- Occupancy: apply 7 weight_flip 0->1->0 pairs, each level held 50 cycles. people_count must step 1..7 and weight_limit_exceeded must rise with count=7. Then one weight_flip_reset pair must give count 0 and the flag 0.
- Same-cycle conflicts:
  - Align a weight_flip rise and a weight_flip_reset rise at count 3: count must go to 0.
  - Align a button3 press with arrived_floor=3'b100: call_pending[2] must stay 0.
- SOS: set sos_flip=1 with call_pending=3'b011. sos_mode must be 1 after 10 edges and call_pending must clear. A button3 press during SOS must give no pulse. After sos_flip=0, a button3 press must pulse normally.
